put_pkt_pacer: RTL and testbench
================================

// Module: put_pkt_pacer
// PURPOSE
//  Paces PUT packets from the key/value packet generator toward the output queues.
//  Sits on the 64-bit data/ctrl packet bus, downstream of the generator.
//  Consumes interpkt_gap_cycles from the op_lut config registers.
//  Enforces a programmable idle gap after each packet; counts packets and gap stalls.
// PARAMETERS
//  DATA_WIDTH  64             packet bus data width
//  CTRL_WIDTH  DATA_WIDTH/8   packet bus ctrl width
//  GAP_WIDTH   32             width of gap config and gap counter
// PORTS
//  clk                  in   1           system clock
//  reset                in   1           asynchronous, active-low reset
//  in_data              in   DATA_WIDTH  packet word from generator
//  in_ctrl              in   CTRL_WIDTH  ctrl: 0xFF=module hdr, 0=payload, other=eop byte mask
//  in_wr                in   1           word valid; legal only while in_rdy=1
//  in_rdy               out  1           pacer can accept a word this cycle
//  out_data             out  DATA_WIDTH  registered packet word
//  out_ctrl             out  CTRL_WIDTH  registered ctrl
//  out_wr               out  1           word transferred downstream this cycle
//  out_rdy              in   1           downstream can accept a word
//  interpkt_gap_cycles  in   GAP_WIDTH   idle cycles required between packets
//  pacing_en            in   1           1=enforce gap; 0=gap forced to 0
//  cnt_clear            in   1           sync clear of both counters
//  pkt_count            out  32          packets forwarded (eop words out), wraps
//  gap_stall_count      out  32          cycles in_wr=1 while GAP held off, saturates
// BEHAVIOUR
//  Reset (reset=0, async): state=HDR, buffer empty, gap_cnt=0, out_wr=0,
//   out_data=0, out_ctrl=0, in_rdy=0 while in reset, both counters=0.
//  One-entry output register (buf_vld). out_wr = buf_vld & out_rdy.
//  in_rdy = (~buf_vld | out_rdy) & (state!=GAP); combinational, no in_wr dependency.
//  Accept = in_wr & in_rdy; the word is loaded into the buffer and buf_vld set.
//  If out_wr and no accept in the same cycle, buf_vld clears.
//  Latency: accepted word appears on out_* next cycle, out_wr when out_rdy=1.
//  FSM:
//   HDR: accept ctrl!=0 words as header. An accepted ctrl==0 word goes to PAY.
//   PAY: an accepted ctrl!=0 word is eop.
//    - gap_cfg = pacing_en ? interpkt_gap_cycles : 0, sampled on the eop-accept cycle.
//    - If gap_cfg==0, go to HDR (back-to-back allowed next cycle).
//    - Otherwise load gap_cnt=gap_cfg and go to GAP.
//   GAP: in_rdy=0; gap_cnt decrements every cycle regardless of out_rdy.
//    - When gap_cnt==1, go to HDR. in_rdy is therefore low for exactly gap_cfg cycles.
//  Config changes during GAP do not affect the running gap.
//  pacing_en falling during GAP does not abort the gap.
//  pkt_count += 1 on out_wr with out_ctrl not 0x00 and not 0xFF, i.e. eop leaving.
//   Wraps 0xFFFFFFFF->0.
//  gap_stall_count += 1 per cycle with state==GAP & in_wr=1. Holds at 0xFFFFFFFF.
//  cnt_clear=1: both counters read 0 next cycle.
//   Clear wins over a simultaneous increment.
//   Packet flow is unaffected.
//  Downstream backpressure (out_rdy=0) with buf_vld=1:
//   - out_* held stable.
//   - in_rdy=0.
//   - gap_cnt still runs.
//  Reset mid-packet or mid-gap: buffered word is discarded. Generator is reset by the same signal.
//  Header-only packet (eop never preceded by ctrl==0 in HDR) is treated as header. Generator must not emit it.
// TESTING
//  1 Reset: hold reset=0 with in_wr=1.
//    -> in_rdy=0, out_wr=0, pkt_count=0, gap_stall_count=0.
//    Release -> in_rdy=1 next cycle.
//  2 Gap: gap=5, pacing_en=1, two 4-word pkts (FF,0,0,0x80) offered back-to-back, out_rdy=1.
//    -> in_rdy low exactly 5 cycles after eop accept.
//    -> pkt2 hdr out 6 cycles after pkt1 eop out.
//    -> gap_stall_count=5, pkt_count=2.
//  3 Zero gap: gap=0 or pacing_en=0, same two pkts.
//    -> no idle cycle between eop and next hdr. gap_stall_count=0.
//  4 Backpressure: out_rdy=0 for 3 cycles mid-payload.
//    -> out_data/out_ctrl stable, in_rdy=0, no word lost or duplicated.
//    -> output sequence equals input sequence.
//  5 Config change in GAP: gap=10; write gap=2 at cycle 3 of gap.
//    -> current gap still 10 cycles; next gap 2 cycles.
//  6 Counters: preload pkt_count 0xFFFFFFFF via force, send 1 pkt -> 0.
//    cnt_clear coincident with eop out -> pkt_count=0.

Source files
------------

// File: rtl/put_pkt_pacer_if.sv
// Packet bus bundle: data/ctrl words with a write strobe (master) and a ready (slave).
interface put_pkt_pacer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, ctrl, wr, input rdy);
  modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/put_pkt_pacer.sv
// Paces PUT packets: one-entry output register plus a programmable idle gap after
// every eop, with a wrapping packet counter and a saturating gap-stall counter.
module put_pkt_pacer #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int GAP_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  put_pkt_pacer_if.slave       src,
  put_pkt_pacer_if.master      dst,
  input  logic [GAP_WIDTH-1:0] interpkt_gap_cycles,
  input  logic                 pacing_en,
  input  logic                 cnt_clear,
  output logic [31:0]          pkt_count,
  output logic [31:0]          gap_stall_count
);

  typedef enum logic [1:0] {HDR, PAY, GAP} state_t;

  localparam logic [CTRL_WIDTH-1:0] CTRL_HDR = '1;

  state_t               state;
  logic                 buf_vld;
  logic                 active;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic [GAP_WIDTH-1:0] gap_cfg;
  logic                 accept;
  logic                 eop_out;

  // active keeps in_rdy low through reset and the first edge after release
  assign src.rdy = active & (~buf_vld | dst.rdy) & (state != GAP);
  assign accept  = src.wr & src.rdy;
  assign dst.wr  = buf_vld & dst.rdy;
  assign gap_cfg = pacing_en ? interpkt_gap_cycles : '0;
  assign eop_out = dst.wr && (dst.ctrl != '0) && (dst.ctrl != CTRL_HDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      buf_vld  <= 1'b0;
      dst.data <= '0;
      dst.ctrl <= '0;
    end else begin
      active <= 1'b1;
      if (accept) begin
        dst.data <= src.data;
        dst.ctrl <= src.ctrl;
        buf_vld  <= 1'b1;
      end else if (dst.wr) begin
        buf_vld <= 1'b0;
      end
    end
  end

  // The gap length is latched on the eop accept, so later config edits only affect the next gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= HDR;
      gap_cnt <= '0;
    end else begin
      case (state)
        HDR: begin
          if (accept && src.ctrl == '0) state <= PAY;
        end
        PAY: begin
          if (accept && src.ctrl != '0) begin
            if (gap_cfg == '0) begin
              state <= HDR;
            end else begin
              gap_cnt <= gap_cfg;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_WIDTH'(1)) state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count       <= '0;
      gap_stall_count <= '0;
    end else if (cnt_clear) begin
      pkt_count       <= '0;
      gap_stall_count <= '0;
    end else begin
      if (eop_out) pkt_count <= pkt_count + 32'd1;
      if (state == GAP && src.wr && gap_stall_count != 32'hFFFF_FFFF)
        gap_stall_count <= gap_stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_put_pkt_pacer.sv
// Directed bench for put_pkt_pacer: a queue-driven generator feeds packets, every word
// leaving the pacer is logged, and gaps/counters are compared to hand-derived values.
module tb_put_pkt_pacer;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] gap_cycles = '0;
  logic        pacing_en = 1'b1;
  logic        cnt_clear = 1'b0;
  logic [31:0] pkt_count;
  logic [31:0] gap_stall_count;

  put_pkt_pacer_if #(.DATA_WIDTH(64)) src_if ();
  put_pkt_pacer_if #(.DATA_WIDTH(64)) dst_if ();

  put_pkt_pacer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .GAP_WIDTH(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .src                 (src_if),
    .dst                 (dst_if),
    .interpkt_gap_cycles (gap_cycles),
    .pacing_en           (pacing_en),
    .cnt_clear           (cnt_clear),
    .pkt_count           (pkt_count),
    .gap_stall_count     (gap_stall_count)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  word_t in_q[$];
  word_t exp_q[$];
  word_t got_q[$];
  int    acc_cyc[$];
  int    out_cyc[$];
  int    cyc;
  int    bp_from, bp_to;
  int    chg_cyc;
  logic [31:0] chg_gap;
  int    pe_off_from, pe_off_to;
  logic  base_pe;
  int    clr_eop_n;
  int    eop_seen;
  word_t held;

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic addPkt(input logic [7:0] tag, input int npay);
    word_t w;
    w.ctrl = 8'hFF; w.data = {tag, 56'h0};
    in_q.push_back(w); exp_q.push_back(w);
    for (int i = 0; i < npay; i++) begin
      w.ctrl = 8'h00; w.data = {tag, 48'h0, 8'(i + 1)};
      in_q.push_back(w); exp_q.push_back(w);
    end
    w.ctrl = 8'h80; w.data = {tag, 56'hE0};
    in_q.push_back(w); exp_q.push_back(w);
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled at the following negedge
  task automatic step();
    src_if.wr = (in_q.size() > 0);
    if (in_q.size() > 0) begin
      src_if.data = in_q[0].data;
      src_if.ctrl = in_q[0].ctrl;
    end
    dst_if.rdy = !(cyc >= bp_from && cyc < bp_to);
    if (cyc == chg_cyc) gap_cycles = chg_gap;
    pacing_en = base_pe && !(cyc >= pe_off_from && cyc < pe_off_to);
    @(negedge clk);
    if (!dst_if.rdy) begin
      checkOutput("bp_in_rdy", 72'(src_if.rdy), 72'(0));
      if (cyc == bp_from) held = {dst_if.ctrl, dst_if.data};
      else checkOutput("bp_hold", {dst_if.ctrl, dst_if.data}, held);
    end
    if (src_if.wr && src_if.rdy) begin
      void'(in_q.pop_front());
      acc_cyc.push_back(cyc);
    end
    if (dst_if.wr) begin
      got_q.push_back({dst_if.ctrl, dst_if.data});
      out_cyc.push_back(cyc);
      if (dst_if.ctrl != 8'h00 && dst_if.ctrl != 8'hFF) begin
        eop_seen++;
        if (eop_seen == clr_eop_n) cnt_clear = 1'b1;
      end
    end
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    cyc++;
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) step();
  endtask

  task automatic startTest(input logic [31:0] gap, input logic pe);
    in_q.delete(); exp_q.delete(); got_q.delete(); acc_cyc.delete(); out_cyc.delete();
    bp_from = -1; bp_to = -1; chg_cyc = -1; chg_gap = '0;
    pe_off_from = -1; pe_off_to = -1; clr_eop_n = -1; eop_seen = 0;
    gap_cycles = gap; base_pe = pe; pacing_en = pe;
    src_if.wr = 1'b0; dst_if.rdy = 1'b1; cnt_clear = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
  endtask

  task automatic checkSequence(input string tag);
    checkOutput({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput({tag, "_word"}, got_q[i], exp_q[i]);
  endtask

  task automatic checkGap(input string tag, input int eop_idx, input int exp_idle);
    if (acc_cyc.size() > eop_idx + 1)
      checkOutput(tag, 72'(acc_cyc[eop_idx + 1] - acc_cyc[eop_idx] - 1), 72'(exp_idle));
    else
      checkOutput({tag, "_missing"}, 72'(acc_cyc.size()), 72'(eop_idx + 2));
  endtask

  initial begin
    // Reset holds the pacer closed even while the generator asserts in_wr
    reset = 1'b0;
    src_if.wr = 1'b1; src_if.data = 64'hDEAD_BEEF_0000_0001; src_if.ctrl = 8'hFF;
    dst_if.rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_rdy", 72'(src_if.rdy), 72'(0));
    checkOutput("rst_out_wr", 72'(dst_if.wr), 72'(0));
    checkOutput("rst_out_word", {dst_if.ctrl, dst_if.data}, 72'(0));
    checkOutput("rst_pkt_count", 72'(pkt_count), 72'(0));
    checkOutput("rst_stall_count", 72'(gap_stall_count), 72'(0));
    reset = 1'b1; src_if.wr = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_release_rdy", 72'(src_if.rdy), 72'(1));

    // gap=5: eop accept, 5 idle cycles, next header; hdr out 6 cycles after eop out
    startTest(32'd5, 1'b1);
    addPkt(8'h01, 2); addPkt(8'h02, 2);
    applyStimulus(30);
    checkGap("gap5_idle", 3, 5);
    if (out_cyc.size() >= 5)
      checkOutput("gap5_out_spacing", 72'(out_cyc[4] - out_cyc[3]), 72'(6));
    else
      checkOutput("gap5_out_missing", 72'(out_cyc.size()), 72'(8));
    checkSequence("gap5_seq");
    checkOutput("gap5_stalls", 72'(gap_stall_count), 72'(5));
    checkOutput("gap5_pkts", 72'(pkt_count), 72'(2));
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    checkOutput("clear_pkts", 72'(pkt_count), 72'(0));
    checkOutput("clear_stalls", 72'(gap_stall_count), 72'(0));

    // gap=0 and pacing disabled both give back-to-back packets
    startTest(32'd0, 1'b1);
    addPkt(8'h03, 2); addPkt(8'h04, 2);
    applyStimulus(20);
    checkGap("gap0_idle", 3, 0);
    if (out_cyc.size() >= 5)
      checkOutput("gap0_out_spacing", 72'(out_cyc[4] - out_cyc[3]), 72'(1));
    checkOutput("gap0_stalls", 72'(gap_stall_count), 72'(0));
    checkOutput("gap0_pkts", 72'(pkt_count), 72'(2));

    startTest(32'd5, 1'b0);
    addPkt(8'h05, 2); addPkt(8'h06, 2);
    applyStimulus(20);
    checkGap("pe_off_idle", 3, 0);
    checkOutput("pe_off_stalls", 72'(gap_stall_count), 72'(0));
    checkSequence("pe_off_seq");

    // Downstream stalls for 3 cycles while payload is buffered
    startTest(32'd0, 1'b1);
    addPkt(8'h07, 4);
    bp_from = 3; bp_to = 6;
    applyStimulus(20);
    checkSequence("bp_seq");
    checkOutput("bp_pkts", 72'(pkt_count), 72'(1));

    // Running gap keeps its length despite config edits and pacing_en dropping
    startTest(32'd10, 1'b1);
    addPkt(8'h08, 2); addPkt(8'h09, 2); addPkt(8'h0A, 2);
    chg_cyc = 6; chg_gap = 32'd2;
    pe_off_from = 7; pe_off_to = 9;
    applyStimulus(40);
    checkGap("cfg_gap_first", 3, 10);
    checkGap("cfg_gap_second", 7, 2);
    checkOutput("cfg_stalls", 72'(gap_stall_count), 72'(12));
    checkOutput("cfg_pkts", 72'(pkt_count), 72'(3));
    checkSequence("cfg_seq");

    // Packet counter wraps from all-ones, and clear beats a coincident increment
    startTest(32'd0, 1'b1);
    force dut.pkt_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.pkt_count;
    checkOutput("wrap_preload", 72'(pkt_count), 72'(32'hFFFF_FFFF));
    addPkt(8'h0B, 2);
    applyStimulus(8);
    checkOutput("wrap_pkts", 72'(pkt_count), 72'(0));
    clr_eop_n = eop_seen + 2;
    addPkt(8'h0C, 2); addPkt(8'h0D, 2);
    applyStimulus(14);
    checkOutput("clr_vs_inc_pkts", 72'(pkt_count), 72'(0));
    checkOutput("clr_eops_seen", 72'(eop_seen), 72'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
